// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi_lite_regbank.
// Ports (signals): AW channel (AWADDR/AWPROT/AWVALID/AWREADY),
//   W channel (WDATA/WSTRB/WVALID/WREADY), B channel (BRESP/BVALID/BREADY),
//   AR channel (ARADDR/ARPROT/ARVALID/ARREADY), R channel (RDATA/RRESP/RVALID/RREADY).
// Modports: slave (register bank side), master (bus initiator side).
interface axi_lite_regbank_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 6
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank: NUM_REGS registers, each
// read/write, read-only (reads status_in) or write-pulse (self-clearing).
// Ports:
//   ACLK, ARESET  clock, synchronous active-high reset
//   s_axi         AXI4-Lite slave bundle (axi_lite_regbank_if.slave)
//   reg_out       flattened register contents, reg i at [i*DW +: DW]
//   status_in     read values for read-only registers
//   wr_strobe     one-cycle pulse per register on write commit
//   rd_strobe     one-cycle pulse per register after a decoded read
module axi_lite_regbank #(
    parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned         C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned         NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK         = '0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    axi_lite_regbank_if.slave                      s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_strobe,
    output logic [NUM_REGS-1:0]                    rd_strobe
);
    localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NB  = DW / 8;
    localparam int unsigned LSB = $clog2(NB);
    localparam int unsigned IW  = C_S_AXI_ADDR_WIDTH - LSB;
    // Read-only wins when both masks claim a register.
    localparam logic [NUM_REGS-1:0] PULSE_EFF = PULSE_MASK & ~RO_MASK;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic                aw_held_q, aw_held_d;
    logic [IW-1:0]       aw_idx_q, aw_idx_d;
    logic                w_held_q, w_held_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]       wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    resp_e               bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    resp_e               rresp_q, rresp_d;
    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
    logic [NUM_REGS-1:0] rd_strobe_q, rd_strobe_d;

    logic                aw_hs, w_hs, ar_hs;
    logic [IW-1:0]       ar_idx;
    logic [DW-1:0]       wmask;
    logic                unused_inputs;

    assign s_axi.AWREADY = !aw_held_q && !bvalid_q;
    assign s_axi.WREADY  = !w_held_q && !bvalid_q;
    assign s_axi.ARREADY = !rvalid_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

    assign aw_hs  = s_axi.AWVALID && s_axi.AWREADY;
    assign w_hs   = s_axi.WVALID && s_axi.WREADY;
    assign ar_hs  = s_axi.ARVALID && s_axi.ARREADY;
    assign ar_idx = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];

    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;

    // PROT and sub-word address bits carry no meaning for this bank.
    assign unused_inputs = ^{s_axi.AWPROT, s_axi.ARPROT,
                             s_axi.AWADDR[LSB-1:0], s_axi.ARADDR[LSB-1:0], status_in};

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DW +: DW] = regs_q[i];
        end
    end

    always_comb begin
        aw_held_d   = aw_held_q;
        aw_idx_d    = aw_idx_q;
        w_held_d    = w_held_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        rd_strobe_d = '0;
        wmask       = '0;

        for (int unsigned b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{wstrb_q[b]}};
        end

        // Pulse registers live for one cycle only.
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (PULSE_EFF[i]) begin
                regs_d[i] = '0;
            end
        end

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.WDATA;
            wstrb_d  = s_axi.WSTRB;
        end
        if (bvalid_q && s_axi.BREADY) begin
            bvalid_d = 1'b0;
        end

        // Commit: both halves held. BVALID is low here, so no handshake can race it.
        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(aw_idx_q) == i) begin
                    bresp_d        = RESP_OKAY;
                    wr_strobe_d[i] = 1'b1;
                    if (!RO_MASK[i]) begin
                        // regs_d of a pulse register is already zero, so unstrobed bytes stay 0.
                        regs_d[i] = (regs_d[i] & ~wmask) | (wdata_q & wmask);
                    end
                end
            end
        end

        if (rvalid_q && s_axi.RREADY) begin
            rvalid_d = 1'b0;
        end
        // Reads sample regs_q, so a same-cycle commit is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(ar_idx) == i) begin
                    rresp_d        = RESP_OKAY;
                    rd_strobe_d[i] = 1'b1;
                    if (RO_MASK[i]) begin
                        rdata_d = status_in[i*DW +: DW];
                    end else if (!PULSE_EFF[i]) begin
                        rdata_d = regs_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q   <= 1'b0;
            aw_idx_q    <= '0;
            w_held_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q   <= aw_held_d;
            aw_idx_q    <= aw_idx_d;
            w_held_q    <= w_held_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed steps followed by random
// traffic, all checked against an array model of the register bank.
module tb_axi_lite_regbank;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned NR = 8;
    localparam logic [NR-1:0] RO = 8'h10;
    localparam logic [NR-1:0] PU = 8'h20;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] status_in;
    logic [NR-1:0]    wr_strobe;
    logic [NR-1:0]    rd_strobe;

    axi_lite_regbank_if #(.DW(DW), .AW(AW)) bus ();

    axi_lite_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR),
        .RO_MASK(RO),
        .PULSE_MASK(PU)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .s_axi(bus),
        .reg_out(reg_out),
        .status_in(status_in),
        .wr_strobe(wr_strobe),
        .rd_strobe(rd_strobe)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [NR];

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    // Expected reg_out; register pidx shows pval instead of its stored value.
    function automatic logic [NR*DW-1:0] exp_regs(input int pidx, input logic [31:0] pval);
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = (i == pidx) ? pval : model[i];
        return r;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctl"}, {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP},
            {3'b111, 2'b00, 4'b0000});
        chk({tag, "_rdata"}, bus.RDATA, 0);
        chk({tag, "_strobes"}, {wr_strobe, rd_strobe}, 0);
        chk({tag, "_regs"}, reg_out, 0);
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: together.
    task automatic bus_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, output logic [1:0] resp, output logic [NR-1:0] stb_or,
                             output int stb_cnt, output int lat, output logic [NR*DW-1:0] regs_c,
                             output logic held_bad, output logic tmo);
        int n = 0, hs_last = -100, bfirst = -1;
        int dly = (lead < 0) ? -lead : lead;
        bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
        resp = 2'b11; stb_or = '0; stb_cnt = 0; regs_c = '0; held_bad = 0;
        @(negedge clk);
        bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb; bus.BREADY = 1'b1;
        if (lead >= 0) bus.WVALID = 1'b1;
        if (lead <= 0) bus.AWVALID = 1'b1;
        while (!b_done && n < 60) begin
            if (lead > 0 && !aw_done && !bus.AWVALID && n >= dly) bus.AWVALID = 1'b1;
            if (lead < 0 && !w_done && !bus.WVALID && n >= dly) bus.WVALID = 1'b1;
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            b_hs  = bus.BVALID && bus.BREADY;
            if (w_done && !aw_done && bus.WREADY) held_bad = 1;
            if (aw_done && !w_done && bus.AWREADY) held_bad = 1;
            if (aw_hs || w_hs) hs_last = n;
            if (b_hs) resp = bus.BRESP;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (aw_hs) begin bus.AWVALID = 1'b0; aw_done = 1; end
            if (w_hs) begin bus.WVALID = 1'b0; w_done = 1; end
            if (b_hs) b_done = 1;
            if (bus.BVALID && bfirst < 0) begin bfirst = n; regs_c = reg_out; end
            if (wr_strobe != '0) begin stb_cnt++; stb_or |= wr_strobe; end
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        lat = bfirst - hs_last;
        tmo = !b_done;
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        int idx = int'(addr[AW-1:2]);
        int pidx = -1;
        logic [31:0] pval = '0;
        logic [1:0] resp;
        logic [NR-1:0] stb_or;
        int stb_cnt, lat;
        logic [NR*DW-1:0] regs_c;
        logic held_bad, tmo;
        bus_write(addr, data, strb, lead, resp, stb_or, stb_cnt, lat, regs_c, held_bad, tmo);
        if (idx < NR) begin
            if (RO[idx]) begin
            end else if (PU[idx]) begin
                pidx = idx;
                pval = merge(32'h0, data, strb);
            end else begin
                model[idx] = merge(model[idx], data, strb);
            end
        end
        chk({tag, "_timeout"}, tmo, 0);
        chk({tag, "_bresp"}, resp, (idx < NR) ? 2'b00 : 2'b10);
        chk({tag, "_wr_strobe"}, {stb_cnt[7:0], stb_or}, (idx < NR) ? {8'd1, NR'(1) << idx} : 16'h0);
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_held_ready"}, held_bad, 0);
        chk({tag, "_regs_commit"}, regs_c, exp_regs(pidx, pval));
        chk({tag, "_regs_after"}, reg_out, exp_regs(-1, 0));
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] addr);
        int idx = int'(addr[AW-1:2]);
        int n = 0, hs_at = -100, cnt = 0, lat = -1;
        bit got = 0, ar_hs;
        logic [31:0] data = '1, edata;
        logic [1:0] resp = 2'b11;
        logic [NR-1:0] sor = '0;
        if (idx >= NR) edata = '0;
        else if (RO[idx]) edata = status_in[idx*DW +: DW];
        else if (PU[idx]) edata = '0;
        else edata = model[idx];
        @(negedge clk);
        bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        while (!got && n < 60) begin
            ar_hs = bus.ARVALID && bus.ARREADY;
            if (ar_hs) hs_at = n;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ar_hs) bus.ARVALID = 1'b0;
            if (rd_strobe != '0) begin cnt++; sor |= rd_strobe; end
            if (bus.RVALID) begin data = bus.RDATA; resp = bus.RRESP; got = 1; lat = n - hs_at; end
        end
        bus.ARVALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (rd_strobe != '0) begin cnt++; sor |= rd_strobe; end
        chk({tag, "_timeout"}, got, 1);
        chk({tag, "_rdata"}, data, edata);
        chk({tag, "_rresp"}, resp, (idx < NR) ? 2'b00 : 2'b10);
        chk({tag, "_latency"}, lat, 1);
        chk({tag, "_rd_strobe"}, {cnt[7:0], sor}, (idx < NR) ? {8'd1, NR'(1) << idx} : 16'h0);
        chk({tag, "_rvalid_done"}, bus.RVALID, 0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int pre;
        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;
        status_in = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Sequential RW
        for (int i = 0; i < 4; i++) do_write("seq_wr", AW'(i * 4), 32'(i + 1), 4'hF, 0);
        for (int i = 0; i < 4; i++) do_read("seq_rd", AW'(i * 4));

        // AW/W ordering
        do_write("ord_wfirst", 6'h08, 32'hA5A5A5A5, 4'hF, 3);
        do_write("ord_clr1", 6'h08, 32'h0, 4'hF, 0);
        do_write("ord_awfirst", 6'h08, 32'hA5A5A5A5, 4'hF, -3);
        do_write("ord_clr2", 6'h08, 32'h0, 4'hF, 0);
        do_write("ord_same", 6'h08, 32'hA5A5A5A5, 4'hF, 0);
        do_read("ord_rd", 6'h08);

        // Byte strobes
        do_write("strb_init", 6'h04, 32'h11223344, 4'hF, 0);
        do_write("strb_part", 6'h04, 32'hFFFFFFFF, 4'h5, 0);
        do_read("strb_rd", 6'h04);
        chk("strb_value", model[1], 32'h11FF33FF);

        // Read-only and pulse
        status_in[4*DW +: DW] = 32'hCAFE0001;
        do_write("ro_wr", 6'h10, 32'h12345678, 4'hF, 0);
        do_read("ro_rd", 6'h10);
        do_write("pulse_wr", 6'h14, 32'h3, 4'hF, 0);
        do_read("pulse_rd", 6'h14);

        // Decode errors
        do_write("dec_wr", 6'h20, 32'hDEADBEEF, 4'hF, 0);
        do_read("dec_rd", 6'h3C);

        // Random traffic, unaligned addresses included
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = $urandom();
            ra = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                pre = int'($urandom_range(0, 6)) - 3;
                do_write("rnd_wr", ra, $urandom(), 4'($urandom_range(0, 15)), pre);
            end else begin
                do_read("rnd_rd", ra);
            end
        end

        // Backpressure then reset with BVALID pending
        @(negedge clk);
        bus.AWADDR = 6'h18; bus.WDATA = 32'h600DF00D; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        model[6] = 32'h600DF00D;
        for (int i = 0; i < 10 && !bus.BVALID; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_bvalid_seen", bus.BVALID, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold", {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, 5'b1_00_0_0);
        end
        chk("bp_regs", reg_out, exp_regs(-1, 0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        do_write("post_rst_wr", 6'h1C, 32'h0BADCAFE, 4'hF, 0);
        do_read("post_rst_rd", 6'h1C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
